opc5ls_io_timer: RTL

//  Bus responder on the IO side of the OPC5LS CPU bus: decodes IO cycles (vio) from the CPU,

---
 rtl/opc5ls_io_timer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/opc5ls_io_timer.sv
// IO-side bus responder for the OPC5LS CPU: wait-state generation via clken and a
// five-register prescaled down-counter timer with a level, active-low interrupt.
module opc5ls_io_timer #(
    parameter logic [15:0] BASE_ADDR   = 16'hFE00,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned INT_LINE    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        rnw,
    input  logic        vio,
    output logic [15:0] rdata,
    output logic        clken,
    output logic [1:0]  int_b
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic        sel;
    logic [2:0]  idx;
    logic [3:0]  wcnt;
    logic        wait_done;
    logic        commit;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_reload;
    logic        wr_prescale;

    logic        en;
    logic        ie;
    logic        ar;
    logic        exp_flag;
    logic        irq_n;
    logic [15:0] reload;
    logic [15:0] count;
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic        tick;
    logic        expire;

    assign sel       = vio && (address[15:3] == BASE_ADDR[15:3]);
    assign idx       = address[2:0];
    assign wait_done = (wcnt == WS);
    assign clken     = ~sel | wait_done;

    // Only the completing cycle of a selected write may change register state.
    assign commit      = sel & wait_done & ~rnw;
    assign wr_ctrl     = commit && (idx == 3'd0);
    assign wr_status   = commit && (idx == 3'd1);
    assign wr_reload   = commit && (idx == 3'd2);
    assign wr_prescale = commit && (idx == 3'd4);

    // A RELOAD write on the same edge as a tick swallows that tick entirely.
    assign tick   = en && (pcnt == prescale);
    assign expire = tick && !wr_reload && (count == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt     <= 4'd0;
            en       <= 1'b0;
            ie       <= 1'b0;
            ar       <= 1'b0;
            exp_flag <= 1'b0;
            irq_n    <= 1'b1;
            reload   <= 16'hFFFF;
            count    <= 16'hFFFF;
            prescale <= 16'd0;
            pcnt     <= 16'd0;
        end else begin
            wcnt <= (sel && !wait_done) ? wcnt + 4'd1 : 4'd0;

            if (wr_reload) begin
                reload <= wdata;
                count  <= wdata;
            end else if (tick) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else if (ar) begin
                    count <= reload;
                end
            end

            if (wr_reload || wr_prescale) begin
                pcnt <= 16'd0;
            end else if (en) begin
                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
            end

            if (wr_prescale) begin
                prescale <= wdata;
            end

            // An explicit CTRL write overrides the one-shot auto-stop on the same edge.
            if (wr_ctrl) begin
                en <= wdata[0];
                ie <= wdata[1];
                ar <= wdata[2];
            end else if (expire && !ar) begin
                en <= 1'b0;
            end

            if (expire) begin
                exp_flag <= 1'b1;
            end else if (wr_status && wdata[0]) begin
                exp_flag <= 1'b0;
            end

            irq_n <= ~(exp_flag & ie);
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (sel && rnw) begin
            case (idx)
                3'd0:    rdata = {13'd0, ar, ie, en};
                3'd1:    rdata = {15'd0, exp_flag};
                3'd2:    rdata = reload;
                3'd3:    rdata = count;
                3'd4:    rdata = prescale;
                default: rdata = 16'h0000;
            endcase
        end
    end

    assign int_b = (INT_LINE == 1) ? {irq_n, 1'b1} : {1'b1, irq_n};

endmodule
